// File: rtl/cnn_pkg.sv
// Types and default dimensions shared by the CNN layer blocks.
package cnn_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_PIX_PER_CH = 9216;
  localparam int DEF_LEAD       = 873;

  typedef logic signed [DEF_DATA_W-1:0] pix_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  // One spare bit so the tag can also encode "one past the last channel".
  function automatic int ch_idx_w(input int num_ch);
    return $clog2(num_ch) + 1;
  endfunction

endpackage

// File: rtl/m_valid_delay.sv
// DEPTH-cycle shift register for a valid flag and its tag; out lags in by exactly DEPTH cycles.
// No backpressure: shifts every cycle; any_vld reports whether a flag is still in flight.
module m_valid_delay #(
  parameter int DEPTH = 1,
  parameter int TAG_W = 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_vld,
  output logic [TAG_W-1:0] out_tag,
  output logic             any_vld
);

  logic [DEPTH-1:0] vld_sr;
  logic [TAG_W-1:0] tag_sr [DEPTH];

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_sr[i] <= '0;
      end
    end else begin
      vld_sr[0] <= in_vld;
      tag_sr[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        tag_sr[i] <= tag_sr[i-1];
      end
    end
  end

  assign out_vld = vld_sr[DEPTH-1];
  assign out_tag = tag_sr[DEPTH-1];
  assign any_vld = |vld_sr;

endmodule

// File: rtl/m_layer_input_stream.sv
// Streams NUM_CH x PIX_PER_CH pixels from a synchronous ROM and flags per-channel warm-up via start.
// First map_valid ROM_LAT+1 cycles after frame_go; hold stalls address issue only, in-flight reads still land.
module m_layer_input_stream
  import cnn_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_CH     = 1,
  parameter int PIX_PER_CH = DEF_PIX_PER_CH,
  parameter int LEAD       = DEF_LEAD,
  parameter int ROM_LAT    = 1,
  parameter int ADDR_W     = $clog2(NUM_CH*PIX_PER_CH)
) (
  input  logic                        clk_in,
  input  logic                        rst_n,
  input  logic                        frame_go,
  input  logic                        hold,
  output logic                        rom_en,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic signed [DATA_W-1:0]    rom_dout,
  output logic signed [DATA_W-1:0]    map_out,
  output logic                        map_valid,
  output logic [ch_idx_w(NUM_CH)-1:0] ch_idx,
  output logic                        start,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int                CH_W      = ch_idx_w(NUM_CH);
  localparam int                PIX_W     = $clog2(PIX_PER_CH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CH*PIX_PER_CH - 1);
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(PIX_PER_CH - 1);
  localparam logic [PIX_W-1:0]  LEAD_M1   = PIX_W'(LEAD - 1);
  localparam bit                START_EN  = (LEAD >= 1) && (LEAD < PIX_PER_CH);

  state_t            state, state_nxt;
  logic              go_acc, adv, done_set;
  logic [PIX_W-1:0]  iss_pix, dlv_pix;
  logic [CH_W-1:0]   iss_ch, dly_ch;
  logic              dly_vld, pipe_any;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The address on rom_addr has always been issued once, so a held cycle
  // simply skips issue and the next free cycle moves on to the next address.
  always_comb begin
    state_nxt = state;
    go_acc    = 1'b0;
    adv       = 1'b0;
    done_set  = 1'b0;
    case (state)
      IDLE: begin
        if (frame_go) begin
          go_acc    = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (rom_addr == LAST_ADDR) begin
          state_nxt = DRAIN;
        end else if (!hold) begin
          adv = 1'b1;
        end
      end
      DRAIN: begin
        // Stay here through the frame_done cycle so a coincident frame_go is dropped.
        if (frame_done) begin
          state_nxt = IDLE;
        end else if (!pipe_any) begin
          done_set = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rom_en   <= 1'b0;
      rom_addr <= '0;
      iss_pix  <= '0;
      iss_ch   <= '0;
      busy     <= 1'b0;
    end else begin
      rom_en <= go_acc | adv;
      if (go_acc) begin
        rom_addr <= '0;
        iss_pix  <= '0;
        iss_ch   <= '0;
        busy     <= 1'b1;
      end else if (adv) begin
        rom_addr <= rom_addr + ADDR_W'(1);
        if (iss_pix == LAST_PIX) begin
          iss_pix <= '0;
          iss_ch  <= iss_ch + CH_W'(1);
        end else begin
          iss_pix <= iss_pix + PIX_W'(1);
        end
      end
      if (done_set) begin
        busy <= 1'b0;
      end
    end
  end

  m_valid_delay #(
    .DEPTH (ROM_LAT),
    .TAG_W (CH_W)
  ) u_valid_delay (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .in_vld  (rom_en),
    .in_tag  (iss_ch),
    .out_vld (dly_vld),
    .out_tag (dly_ch),
    .any_vld (pipe_any)
  );

  // Pixels arrive strictly in order, so a wrapping per-channel counter marks channel starts.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      map_out    <= '0;
      map_valid  <= 1'b0;
      ch_idx     <= '0;
      start      <= 1'b0;
      frame_done <= 1'b0;
      dlv_pix    <= '0;
    end else begin
      map_valid  <= dly_vld;
      frame_done <= done_set;
      if (dly_vld) begin
        map_out <= rom_dout;
        ch_idx  <= dly_ch;
        start   <= START_EN && (dlv_pix >= LEAD_M1);
        dlv_pix <= (dlv_pix == LAST_PIX) ? '0 : dlv_pix + PIX_W'(1);
      end else if (done_set) begin
        start   <= 1'b0;
        dlv_pix <= '0;
      end
    end
  end

endmodule

// File: tb/tb_m_layer_input_stream.sv
// Randomised self-checking bench: two instances (ROM latency 1 and 3) against an in-order frame model.
module tb_m_layer_input_stream;

  localparam int DW  = 16;
  localparam int NCH = 2;
  localparam int PPC = 16;
  localparam int LD  = 5;
  localparam int TOT = NCH * PPC;
  localparam int AW  = $clog2(TOT);
  localparam int CW  = $clog2(NCH) + 1;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  logic                 go_a, hold_a, go_b, hold_b;
  logic                 en_a, en_b;
  logic [AW-1:0]        addr_a, addr_b;
  logic signed [DW-1:0] dout_a, dout_b, mo_a, mo_b;
  logic                 mv_a, mv_b, st_a, st_b, bz_a, bz_b, fd_a, fd_b;
  logic [CW-1:0]        ch_a, ch_b;

  logic signed [DW-1:0] rom [TOT];
  logic signed [DW-1:0] pb [3];

  always @(posedge clk_in) dout_a <= rom[addr_a];
  always @(posedge clk_in) begin
    pb[0] <= rom[addr_b];
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign dout_b = pb[2];

  m_layer_input_stream #(
    .DATA_W(DW), .NUM_CH(NCH), .PIX_PER_CH(PPC), .LEAD(LD), .ROM_LAT(1)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .frame_go(go_a), .hold(hold_a),
    .rom_en(en_a), .rom_addr(addr_a), .rom_dout(dout_a),
    .map_out(mo_a), .map_valid(mv_a), .ch_idx(ch_a), .start(st_a),
    .busy(bz_a), .frame_done(fd_a)
  );

  m_layer_input_stream #(
    .DATA_W(DW), .NUM_CH(NCH), .PIX_PER_CH(PPC), .LEAD(LD), .ROM_LAT(3)
  ) dut_lat3 (
    .clk_in(clk_in), .rst_n(rst_n), .frame_go(go_b), .hold(hold_b),
    .rom_en(en_b), .rom_addr(addr_b), .rom_dout(dout_b),
    .map_out(mo_b), .map_valid(mv_b), .ch_idx(ch_b), .start(st_b),
    .busy(bz_b), .frame_done(fd_b)
  );

  typedef struct {
    logic                 en;
    logic [AW-1:0]        addr;
    logic signed [DW-1:0] mo;
    logic                 mv;
    logic [CW-1:0]        ch;
    logic                 st;
    logic                 bz;
    logic                 fd;
  } obs_t;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic obs_t look(input int sel);
    obs_t o;
    if (sel == 0) begin
      o.en = en_a; o.addr = addr_a; o.mo = mo_a; o.mv = mv_a;
      o.ch = ch_a; o.st = st_a; o.bz = bz_a; o.fd = fd_a;
    end else begin
      o.en = en_b; o.addr = addr_b; o.mo = mo_b; o.mv = mv_b;
      o.ch = ch_b; o.st = st_b; o.bz = bz_b; o.fd = fd_b;
    end
    return o;
  endfunction

  task automatic drive(input int sel, input logic g, input logic h);
    if (sel == 0) begin
      go_a = g; hold_a = h;
    end else begin
      go_b = g; hold_b = h;
    end
  endtask

  // Expected frame: pixels rom[0..TOT-1] in order, channel = index / PPC,
  // start high once index within its channel reaches LD-1.
  task automatic run_frame(input int sel, input int lat, input int hold_addr, input int hold_len,
                           input bit rnd, input bit spam);
    int   idx, first, last, done_at, gaps, gap_after, hcnt, prev;
    bit   trig, h, g;
    obs_t o;
    idx = 0; first = -1; last = -1; done_at = -1; gaps = 0; gap_after = -1;
    hcnt = 0; prev = -1; trig = 1'b0;
    drive(sel, 1'b1, 1'b0);
    @(negedge clk_in);
    drive(sel, 1'b0, 1'b0);
    o = look(sel);
    chk("busy_rise", o.bz, 1);
    chk("en_rise", o.en, 1);
    chk("addr_first", o.addr, 0);
    for (int t = 1; t < 400; t++) begin
      o = look(sel);
      if (o.mv) begin
        if (first < 0) first = t;
        if (last >= 0 && t - last > 1) begin
          gaps += t - last - 1;
          gap_after = prev;
        end
        if (idx < TOT) begin
          chk("pix_val", o.mo, rom[idx]);
          chk("pix_ch", o.ch, idx / PPC);
          chk("pix_start", o.st, ((idx % PPC) >= LD - 1));
        end else begin
          chk("extra_pix", o.mv, 0);
        end
        prev = o.mo;
        idx++;
        last = t;
      end
      if (o.fd) begin
        done_at = t;
        chk("start_clr", o.st, 0);
        chk("busy_fall", o.bz, 0);
      end
      if (hold_len > 0 && !trig && o.en && o.addr == AW'(hold_addr)) begin
        trig = 1'b1;
        hcnt = hold_len;
      end
      h = rnd ? ($urandom_range(0, 3) == 0) : (hcnt > 0);
      if (hcnt > 0) hcnt--;
      g = o.fd ? spam : (spam && o.bz && ($urandom_range(0, 2) == 0));
      drive(sel, g, h);
      if (o.fd) break;
      @(negedge clk_in);
    end
    @(negedge clk_in);
    o = look(sel);
    chk("go_at_done_ignored", o.bz, 0);
    chk("done_one_shot", o.fd, 0);
    chk("start_low_after", o.st, 0);
    drive(sel, 1'b0, 1'b0);
    chk("done_seen", (done_at > 0), 1);
    chk("pix_count", idx, TOT);
    chk("first_vld", first - 1, lat + 1);
    chk("done_after_last", done_at, last + 1);
    if (!rnd) chk("done_time", done_at - 1, TOT + lat + 1 + hold_len);
    if (hold_len > 0) begin
      chk("gap_len", gaps, hold_len);
      chk("gap_after", gap_after, hold_addr);
    end
  endtask

  task automatic async_reset_test();
    obs_t o;
    bit   hit;
    hit = 1'b0;
    drive(0, 1'b1, 1'b0);
    @(negedge clk_in);
    drive(0, 1'b0, 1'b0);
    for (int t = 0; t < 60 && !hit; t++) begin
      o = look(0);
      if (o.en && o.addr == AW'(10)) hit = 1'b1;
      else @(negedge clk_in);
    end
    chk("reach_addr10", hit, 1);
    #2 rst_n = 1'b0;
    #1 o = look(0);
    chk("arst_clear", {o.en, o.addr, o.mo, o.mv, o.ch, o.st, o.bz, o.fd}, 0);
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk_in);
      o = look(0);
      chk("no_stray_vld", {o.mv, o.bz, o.en}, 0);
    end
  endtask

  initial begin
    obs_t oa, ob;
    go_a = 1'b0; hold_a = 1'b0; go_b = 1'b0; hold_b = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < TOT; i++) rom[i] = DW'(i);
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_in);
      oa = look(0);
      ob = look(1);
      chk("idle_quiet_a", {oa.en, oa.addr, oa.mo, oa.mv, oa.ch, oa.st, oa.bz, oa.fd}, 0);
      chk("idle_quiet_b", {ob.en, ob.addr, ob.mo, ob.mv, ob.ch, ob.st, ob.bz, ob.fd}, 0);
    end

    run_frame(0, 1, -1, 0, 1'b0, 1'b0);
    run_frame(0, 1, 7, 3, 1'b0, 1'b0);
    run_frame(0, 1, -1, 0, 1'b0, 1'b1);
    run_frame(0, 1, -1, 0, 1'b0, 1'b0);
    async_reset_test();
    run_frame(0, 1, -1, 0, 1'b0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < TOT; i++) rom[i] = DW'($urandom_range(0, 65535));
      run_frame(0, 1, -1, 0, 1'b1, 1'b1);
    end

    for (int i = 0; i < TOT; i++) rom[i] = DW'(i);
    run_frame(1, 3, -1, 0, 1'b0, 1'b0);
    run_frame(1, 3, 7, 3, 1'b0, 1'b0);
    run_frame(1, 3, -1, 0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
